acc_bcd_converter: RTL
======================

Name: acc_bcd_converter

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) for the 17-bit accumulator value.
- Feeds the six HEX digit drivers so the running sum shows in decimal instead of hex.
- Sits between the accumulator register output and the HexDriver instances.
- Start/Busy/Done handshake, so the accumulator control can request a refresh after each load.

Parameters:
- WIDTH, 17, binary input width in bits.
- DIGITS, 6, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH-1; default 131071 fits in 6 digits.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_Clear  input  1  asynchronous, active-low reset.
- Start  input  1  conversion request, sampled in IDLE only.
- Bin  input  WIDTH  unsigned binary value; captured on the accepting edge.
- BCD  output  4*DIGITS  converted result; digit i = BCD[4i+3:4i], digit 0 least significant.
- Busy  output  1  high while conversion is in progress.
- Done  output  1  one-cycle pulse when BCD has just been updated.
- Blank  output  DIGITS  leading-zero flags (see Optional Feature).

Behaviour:
- Clock and reset: one clock (Clk); reset is asynchronous and active-low (Reset_Clear).
- Reset (Reset_Clear=0, any time, including mid-conversion):
  - state=IDLE; BCD=0; Busy=0; Done=0; Blank=0.
  - Internal shift register, scratch BCD and bit counter are cleared.
  - Any conversion in progress is discarded.
- States: IDLE, SHIFT.
- IDLE, Start=1 at edge t0:
  - Capture Bin into the shift register; clear scratch BCD; counter=WIDTH.
  - Go to SHIFT; Busy=1 from t0.
- IDLE, Start=0: hold; BCD keeps its last result.
- SHIFT, each edge t0+1 .. t0+WIDTH:
  - First, every scratch digit >= 5 gets +3 (4-bit add, no carry out).
  - Then shift {scratch, shiftreg} left by 1; the shift-register MSB enters scratch bit 0.
  - Decrement the counter.
- Edge t0+WIDTH (counter reaches 0):
  - Load the final scratch value into BCD; Done=1 for exactly one cycle; Busy=0; go to IDLE.
- Latency: Done is high in the cycle after edge t0+WIDTH. Default is 17 cycles from the Start-sampling edge.
- Start while Busy=1: ignored, not queued.
- Start=1 during the Done cycle (state already IDLE): accepted; back-to-back conversions have no dead cycle.
- Bin changes during SHIFT: no effect; the captured value is used.
- BCD changes only on the completion edge (or reset). It never shows partial values.
- Arithmetic:
  - Bin is unsigned. The 17-bit accumulator carry (bit 16) is part of Bin.
  - Each output digit is always in 0..9.
- Done and Busy are registered outputs; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: ACC_BCD_LEADING_BLANK_EN.
- Defined:
  - Blank[i]=1 when digit i and all more-significant digits are 0.
  - Blank[0] is always 0, so value 0 shows a single "0".
  - Blank is registered and updated on the same edge as BCD.
  - The top level uses Blank to turn off the unused HEX segments.
- Undefined: Blank is tied to all zeros; no extra logic is generated.

Test Plan:
- Reset, then Bin=17'h00000 with Start pulsed -> Done on cycle 17; BCD=24'h000000; Blank=6'b111110 (with macro).
- Bin=17'h1FFFF (131071) with Start -> BCD=24'h131071 when Done=1; Busy high for exactly 17 cycles; Done high for 1 cycle.
- Bin=17'h03039 (12345), then change Bin to 17'h00007 and hold Start=1 while Busy -> BCD=24'h012345; the second request is ignored until IDLE.
- Start for Bin=100, then Start held high in the Done cycle with Bin=17'h00042 -> first BCD=24'h000100; second BCD=24'h000066 exactly 17 cycles later; Blank=6'b111100 (with macro).
- Start for Bin=99999, deassert Reset_Clear at cycle 8 for one cycle -> BCD=0, Busy=0, Done never pulses; a fresh Start afterwards gives 24'h099999.
- Compare against a reference model over 2000 random Bin values in 0..131071 with random Start gaps -> every Done cycle's BCD equals the decimal digits of the captured Bin.

Source files
------------

// File: rtl/acc_bcd_converter.sv
// acc_bcd_converter
//   Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock)
//   for the accumulator value. The HEX digit drivers can then show the running
//   sum in decimal. A Start/Busy/Done handshake lets the accumulator control
//   request a refresh after each load.
//
// Ports:
//   Clk          system clock, rising edge
//   Reset_Clear  asynchronous, active-low reset
//   Start        conversion request, sampled only while idle
//   Bin          unsigned binary value, captured on the accepting edge
//   BCD          converted result, digit i = BCD[4i+3:4i], digit 0 least significant
//   Busy         high while a conversion is in progress
//   Done         one-cycle pulse when BCD has just been updated
//   Blank        leading-zero flags, updated together with BCD
//
// Configuration:
//   ACC_BCD_LEADING_BLANK_EN  when defined, Blank[i] is set when digit i and all
//                             more-significant digits are zero (Blank[0] stays 0).
//                             When undefined, Blank is tied to zero.

module acc_bcd_converter #(
   parameter int unsigned WIDTH  = 17,
   parameter int unsigned DIGITS = 6
) (
   input  logic                  Clk,
   input  logic                  Reset_Clear,
   input  logic                  Start,
   input  logic [WIDTH-1:0]      Bin,
   output logic [4*DIGITS-1:0]   BCD,
   output logic                  Busy,
   output logic                  Done,
   output logic [DIGITS-1:0]     Blank
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam int unsigned BcdW = 4 * DIGITS;

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  shift_q, shift_d;
   logic [BcdW-1:0]   scratch_q, scratch_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [BcdW-1:0]   bcd_q, bcd_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [BcdW-1:0]       adj;
   logic [BcdW+WIDTH-1:0] step;
   logic                  finish;

   // One conversion step: add 3 to every digit >= 5, then shift the combined
   // {scratch, shift} register left so the binary MSB enters scratch bit 0.
   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (adj[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
         end
      end
      step = {adj, shift_q} << 1;
   end

   assign finish = (state_q == StShift) && (cnt_q == CntW'(1));

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            busy_d = 1'b0;
            if (Start) begin
               shift_d   = Bin;
               scratch_d = '0;
               cnt_d     = CntW'(WIDTH);
               busy_d    = 1'b1;
               state_d   = StShift;
            end
         end
         StShift: begin
            scratch_d = step[BcdW+WIDTH-1:WIDTH];
            shift_d   = step[WIDTH-1:0];
            cnt_d     = cnt_q - CntW'(1);
            if (finish) begin
               // BCD is only ever loaded with a complete result
               bcd_d   = step[BcdW+WIDTH-1:WIDTH];
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_Clear) begin
      if (!Reset_Clear) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign BCD  = bcd_q;
   assign Busy = busy_q;
   assign Done = done_q;

`ifdef ACC_BCD_LEADING_BLANK_EN
   logic [DIGITS-1:0] blank_q, blank_d;

   // Walk from the top digit down; a digit blanks only while everything above it is zero.
   always_comb begin
      logic run;
      blank_d = blank_q;
      run     = 1'b1;
      if (finish) begin
         for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            run        = run & (step[WIDTH+4*i +: 4] == 4'd0);
            blank_d[i] = run;
         end
         blank_d[0] = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Reset_Clear) begin
      if (!Reset_Clear) begin
         blank_q <= '0;
      end else begin
         blank_q <= blank_d;
      end
   end

   assign Blank = blank_q;
`else
   assign Blank = '0;
`endif

endmodule
